// File: rtl/size_explore_harness.sv
// Serial-load operand wrapper around a selectable arithmetic component (ADDER/MULT/FMA/NONE).
// Define SIZE_EXPLORE_PIPE_EN to add a component-output register stage (2-cycle start->done).
module size_explore_harness #(
   parameter int    INPUT_WIDTH = 8,
   parameter string COMPONENT   = "ADDER"
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int W    = INPUT_WIDTH;
   localparam int W2   = 2 * INPUT_WIDTH;
   localparam int KIND = (COMPONENT == "ADDER") ? 0 :
                         (COMPONENT == "MULT")  ? 1 :
                         (COMPONENT == "FMA")   ? 2 : 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [W-1:0]  op_a, op_a_next;
   logic [W-1:0]  op_b, op_b_next;
   logic [4:0]    bit_count, bit_count_next;
   logic          start_q;
   logic [31:0]   result, result_next;
   logic [W2-1:0] acc, acc_next;
   logic [31:0]   comp_out;
   logic [W:0]    sum;
   logic [W2-1:0] prod;
   logic [W2-1:0] fma_sum;
   logic          start_pulse;
   logic          shift;
   logic          clear;
   logic          unused_pins;

`ifdef SIZE_EXPLORE_PIPE_EN
   logic          busy, busy_next;
   logic [31:0]   pipe, pipe_next;
`endif

   assign shift       = ui_in[2];
   assign clear       = ui_in[6];
   assign start_pulse = ui_in[3] & ~start_q;
   assign unused_pins = &{1'b0, uio_in, ui_in[7]};

   // Component under exploration; result bits above its width stay zero.
   always_comb begin
      sum      = {1'b0, op_a} + {1'b0, op_b};
      prod     = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
      fma_sum  = acc + prod;
      comp_out = '0;
      case (KIND)
         0:       comp_out[W:0]    = sum;
         1:       comp_out[W2-1:0] = prod;
         2:       comp_out[W2-1:0] = fma_sum;
         default: comp_out         = '0;
      endcase
   end

   always_comb begin
      state_next     = state;
      op_a_next      = op_a;
      op_b_next      = op_b;
      bit_count_next = bit_count;
      result_next    = result;
      acc_next       = acc;
`ifdef SIZE_EXPLORE_PIPE_EN
      busy_next      = 1'b0;
      pipe_next      = pipe;
`endif
      if (clear) begin
         result_next    = '0;
         acc_next       = '0;
         bit_count_next = '0;
         state_next     = IDLE;
`ifdef SIZE_EXPLORE_PIPE_EN
      end else if (busy) begin
         // Second half of a pipelined compute; shifts and starts are ignored here.
         result_next = pipe;
         if (KIND == 2)
            acc_next = pipe[W2-1:0];
         state_next  = DONE;
`endif
      end else if (shift) begin
         op_a_next = W'({op_a, ui_in[0]});
         op_b_next = W'({op_b, ui_in[1]});
         if (state == LOAD) begin
            bit_count_next = bit_count + 5'd1;
            if (bit_count + 5'd1 == 5'(W))
               state_next = READY;
         end else begin
            bit_count_next = 5'd1;
            state_next     = (W == 1) ? READY : LOAD;
         end
      end else if (start_pulse && (state == READY || state == DONE)) begin
`ifdef SIZE_EXPLORE_PIPE_EN
         pipe_next   = comp_out;
         busy_next   = 1'b1;
         state_next  = READY;
`else
         result_next = comp_out;
         if (KIND == 2)
            acc_next = fma_sum;
         state_next  = DONE;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         bit_count <= '0;
         start_q   <= 1'b0;
         result    <= '0;
         acc       <= '0;
`ifdef SIZE_EXPLORE_PIPE_EN
         busy      <= 1'b0;
         pipe      <= '0;
`endif
      end else if (ena) begin
         state     <= state_next;
         op_a      <= op_a_next;
         op_b      <= op_b_next;
         bit_count <= bit_count_next;
         start_q   <= ui_in[3];
         result    <= result_next;
         acc       <= acc_next;
`ifdef SIZE_EXPLORE_PIPE_EN
         busy      <= busy_next;
         pipe      <= pipe_next;
`endif
      end
   end

   assign uo_out  = result[{ui_in[5:4], 3'b000} +: 8];
   assign uio_out = {bit_count[3:0], (state == DONE),
                     (state == READY) | (state == DONE), state};
   assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_size_explore_harness.sv
// Directed self-checking bench: ADDER, MULT and FMA instances share stimulus; expected
// values are queued when stimulus is driven and popped when outputs are sampled.
module tb_size_explore_harness;

`ifdef SIZE_EXPLORE_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_add, uio_add, oe_add;
   logic [7:0] uo_mul, uio_mul, oe_mul;
   logic [7:0] uo_fma, uio_fma, oe_fma;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   size_explore_harness #(.INPUT_WIDTH(8), .COMPONENT("ADDER")) dut_add (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_add),
      .uio_in(uio_in), .uio_out(uio_add), .uio_oe(oe_add));
   size_explore_harness #(.INPUT_WIDTH(8), .COMPONENT("MULT")) dut_mul (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_mul),
      .uio_in(uio_in), .uio_out(uio_mul), .uio_oe(oe_mul));
   size_explore_harness #(.INPUT_WIDTH(8), .COMPONENT("FMA")) dut_fma (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_fma),
      .uio_in(uio_in), .uio_out(uio_fma), .uio_oe(oe_fma));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic chk(input logic [7:0] obs);
      exp_t e;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $error("FAIL scoreboard_empty: observed %02h required an expected entry", obs);
      end else begin
         e = exp_q.pop_front();
         $display("check %s observed=%02h expected=%02h", e.tag, obs, e.val);
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic sel(input logic [1:0] s);
      ui_in[5:4] = s;
      #1;
   endtask

   task automatic shift_bits(input logic [7:0] a, input logic [7:0] b, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         ui_in[2] = 1'b1;
         ui_in[0] = a[i];
         ui_in[1] = b[i];
         cyc();
      end
      ui_in[2:0] = 3'b000;
   endtask

   task automatic start_op();
      ui_in[3] = 1'b1;
      cyc();
      ui_in[3] = 1'b0;
      repeat (LAT - 1) cyc();
   endtask

   task automatic do_clear();
      ui_in[6] = 1'b1;
      cyc();
      ui_in[6] = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) cyc();
      rst_n = 1'b1;

      // Reset state
      expect_val("reset_uo", 8'h00);      chk(uo_add);
      expect_val("reset_status", 8'h00);  chk(uio_add);
      expect_val("reset_oe", 8'hFF);      chk(oe_add);

      // ADDER: 0xFF + 0x01 = 0x100
      shift_bits(8'hFF, 8'h01, 7, 0);
      expect_val("add_loaded_status", 8'h86); chk(uio_add);
      start_op();
      expect_val("add_done_status", 8'h8F);   chk(uio_add);
      sel(2'd0); expect_val("add_sel0", 8'h00); chk(uo_add);
      sel(2'd1); expect_val("add_sel1", 8'h01); chk(uo_add);
      sel(2'd2); expect_val("add_sel2", 8'h00); chk(uo_add);
      sel(2'd3); expect_val("add_sel3", 8'h00); chk(uo_add);

      // MULT: 0xFF * 0xFF = 0xFE01
      shift_bits(8'hFF, 8'hFF, 7, 0);
      start_op();
      sel(2'd0); expect_val("mul_sel0", 8'h01); chk(uo_mul);
      sel(2'd1); expect_val("mul_sel1", 8'hFE); chk(uo_mul);
      sel(2'd2); expect_val("mul_sel2", 8'h00); chk(uo_mul);
      sel(2'd0); expect_val("add_ff_ff_sel0", 8'hFE); chk(uo_add);

      // FMA: 3*4 accumulated twice = 0x18
      do_clear();
      shift_bits(8'h03, 8'h04, 7, 0);
      start_op();
      cyc();
      start_op();
      expect_val("fma_twice", 8'h18);    chk(uo_fma);
      expect_val("mul_3x4", 8'h0C);      chk(uo_mul);
      expect_val("add_3p4", 8'h07);      chk(uo_add);
      do_clear();
      expect_val("fma_clear_uo", 8'h00);     chk(uo_fma);
      expect_val("fma_clear_status", 8'h00); chk(uio_fma);
      start_op();
      expect_val("fma_idle_start_status", 8'h00); chk(uio_fma);
      expect_val("fma_idle_start_uo", 8'h00);     chk(uo_fma);

      // Start during LOAD at bit_count=5 is ignored
      shift_bits(8'h10, 8'h20, 7, 3);
      ui_in[3] = 1'b1;
      cyc();
      ui_in[3] = 1'b0;
      expect_val("load_start_ignored", 8'h51); chk(uio_add);
      shift_bits(8'h10, 8'h20, 2, 0);
      expect_val("reloaded_status", 8'h86); chk(uio_add);

      // Start latency: 0x10 + 0x20 = 0x30
      ui_in[3] = 1'b1;
      cyc();
      ui_in[3] = 1'b0;
`ifdef SIZE_EXPLORE_PIPE_EN
      expect_val("pipe_busy_status", 8'h86); chk(uio_add);
      cyc();
`endif
      expect_val("start_done_status", 8'h8F); chk(uio_add);
      expect_val("add_0x30", 8'h30);          chk(uo_add);

      // Shift and start together in READY: shift wins, result unchanged
      shift_bits(8'h10, 8'h20, 7, 0);
      ui_in[2] = 1'b1;
      ui_in[1:0] = 2'b00;
      ui_in[3] = 1'b1;
      cyc();
      ui_in[3:0] = 4'b0000;
      expect_val("shift_beats_start", 8'h11); chk(uio_add);
      expect_val("result_kept", 8'h30);       chk(uo_add);
      shift_bits(8'h10, 8'h20, 6, 0);

      // Start held 4 cycles: FMA accumulates exactly once more (0x200 -> 0x400)
      ui_in[3] = 1'b1;
      repeat (4) cyc();
      ui_in[3] = 1'b0;
      cyc();
      sel(2'd1); expect_val("held_start_fma_sel1", 8'h04); chk(uo_fma);
      sel(2'd0); expect_val("held_start_fma_sel0", 8'h00); chk(uo_fma);

      // Asynchronous reset right after a start
      ui_in[3] = 1'b1;
      cyc();
      ui_in[3] = 1'b0;
      rst_n = 1'b0;
      #1;
      expect_val("rst_add_uo", 8'h00);     chk(uo_add);
      expect_val("rst_add_status", 8'h00); chk(uio_add);
      sel(2'd1); expect_val("rst_fma_sel1", 8'h00); chk(uo_fma);
      expect_val("rst_oe", 8'hFF);         chk(oe_fma);
      sel(2'd0);
      cyc();
      rst_n = 1'b1;

      // Clock enable low freezes bit_count
      shift_bits(8'h00, 8'h00, 7, 5);
      expect_val("ena_before", 8'h31); chk(uio_add);
      ena = 1'b0;
      shift_bits(8'h00, 8'h00, 4, 2);
      expect_val("ena_frozen", 8'h31); chk(uio_add);
      ena = 1'b1;
      cyc();

      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
